// File: rtl/fp2bfp_encoder.sv
// FP32 stream to block-floating-point group encoder: fills GRPSIZE elements,
// aligns them to the group's max exponent, presents one group per handshake.
// Optional FP2BFP_ROUND_EN: round-to-nearest (ties away) instead of truncation.
module fp2bfp_encoder #(
    parameter int GRPSIZE    = 16,
    parameter int BFPEXPSIZE = 8,
    parameter int BFPMANSIZE = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_fp_valid,
    input  logic [31:0]           i_fp,
    output logic                  o_fp_ready,
    output logic                  o_grp_valid,
    input  logic                  i_grp_ready,
    output logic [BFPEXPSIZE-1:0] o_grp_E,
    output logic [BFPMANSIZE-1:0] o_grp_M [0:GRPSIZE-1],
    output logic                  o_busy
);

    localparam int CW = $clog2(GRPSIZE);
    localparam int MW = BFPMANSIZE - 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(GRPSIZE - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ALIGN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // Aligns one raw FP32 word against the group exponent; zero/denormal encodes as 0.
    function automatic logic [BFPMANSIZE-1:0] encode_elem(
        input logic [31:0]           w,
        input logic [BFPEXPSIZE-1:0] max_e
    );
        logic [7:0]    e;
        logic [7:0]    d;
        logic [MW-1:0] mag;
`ifdef FP2BFP_ROUND_EN
        logic [MW:0]   t;
        logic [MW:0]   sum;
`else
        logic [MW-1:0] t;
`endif
        e = w[30:23];
        d = max_e - e;
        if (e == 8'd0) begin
            mag = '0;
        end else begin
`ifdef FP2BFP_ROUND_EN
            // Keep one extra guard bit below the magnitude, then round it in.
            t   = {1'b1, w[22:23-MW]} >> d;
            sum = {1'b0, t[MW:1]} + {{MW{1'b0}}, t[0]};
            mag = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
`else
            t   = {1'b1, w[22:24-MW]} >> d;
            mag = t;
`endif
        end
        return {w[31] & (mag != '0), mag};
    endfunction

    state_t                  state_r, state_n;
    logic [CW-1:0]           count_r, count_n;
    logic [BFPEXPSIZE-1:0]   max_e_r, max_e_n;
    logic [BFPEXPSIZE-1:0]   e_in_s;
    logic [BFPEXPSIZE-1:0]   max_cand_s;
    logic                    accept_s;
    logic [31:0]             buffer_r [0:GRPSIZE-1];
    logic                    ready_r;
    logic                    valid_r;
    logic                    busy_r;
    logic [BFPEXPSIZE-1:0]   grp_e_r;
    logic [BFPMANSIZE-1:0]   grp_m_r [0:GRPSIZE-1];

    // Next-state, element counter and running max-exponent logic.
    always_comb begin
        state_n    = state_r;
        count_n    = count_r;
        max_e_n    = max_e_r;
        accept_s   = 1'b0;
        e_in_s     = i_fp[30:23];
        // A zero exponent can never exceed the running max, so zeros drop out here.
        max_cand_s = (e_in_s > max_e_r) ? e_in_s : max_e_r;
        case (state_r)
            S_FILL: begin
                if (i_fp_valid) begin
                    accept_s = 1'b1;
                    count_n  = count_r + CNT_ONE;
                    max_e_n  = max_cand_s;
                    if (count_r == CNT_LAST) begin
                        state_n = S_ALIGN;
                    end else begin
                        state_n = S_FILL;
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            S_ALIGN: begin
                state_n = S_OUT;
            end
            S_OUT: begin
                if (i_grp_ready) begin
                    state_n = S_FILL;
                    max_e_n = '0;
                end else begin
                    state_n = S_OUT;
                end
            end
            default: begin
                state_n = S_FILL;
                count_n = '0;
                max_e_n = '0;
            end
        endcase
    end

    // Control state, handshake flags and aligned group output registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r <= S_FILL;
            count_r <= '0;
            max_e_r <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            grp_e_r <= '0;
            for (int i = 0; i < GRPSIZE; i++) begin
                grp_m_r[i] <= '0;
            end
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            max_e_r <= max_e_n;
            ready_r <= (state_n == S_FILL);
            valid_r <= (state_n == S_OUT);
            busy_r  <= !((state_n == S_FILL) && (count_n == '0));
            if (state_r == S_ALIGN) begin
                grp_e_r <= max_e_r;
                for (int i = 0; i < GRPSIZE; i++) begin
                    grp_m_r[i] <= encode_elem(buffer_r[i], max_e_r);
                end
            end
        end
    end

    // Raw element storage, written in arrival order.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && accept_s) begin
            buffer_r[count_r] <= i_fp;
        end
    end

    assign o_fp_ready  = ready_r;
    assign o_grp_valid = valid_r;
    assign o_busy      = busy_r;
    assign o_grp_E     = grp_e_r;
    assign o_grp_M     = grp_m_r;

endmodule

// File: tb/tb_fp2bfp_encoder.sv
// Directed self-checking bench for fp2bfp_encoder (GRPSIZE=16, 8-bit E, 4-bit M).
module tb_fp2bfp_encoder;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_fp_valid;
    logic [31:0] i_fp;
    logic        o_fp_ready;
    logic        o_grp_valid;
    logic        i_grp_ready;
    logic [7:0]  o_grp_E;
    logic [3:0]  o_grp_M [0:15];
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] grp_vals [0:15];
    logic [3:0]  exp_m    [0:15];

    fp2bfp_encoder #(.GRPSIZE(16), .BFPEXPSIZE(8), .BFPMANSIZE(4)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_fp_valid (i_fp_valid),
        .i_fp       (i_fp),
        .o_fp_ready (o_fp_ready),
        .o_grp_valid(o_grp_valid),
        .i_grp_ready(i_grp_ready),
        .o_grp_E    (o_grp_E),
        .o_grp_M    (o_grp_M),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Feeds grp_vals until 16 elements are accepted; leaves us in the ALIGN cycle.
    task automatic fill_group();
        int   idx = 0;
        int   guard = 0;
        logic rdy;
        while (idx < 16 && guard < 100) begin
            i_fp_valid = 1'b1;
            i_fp       = grp_vals[idx];
            rdy        = o_fp_ready;
            step();
            if (rdy) idx++;
            guard++;
        end
        i_fp_valid = 1'b0;
        checks++;
        if (idx !== 16) begin
            errors++;
            $display("FAIL fill_timeout: accepted %0d, required 16", idx);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_fp_valid = 1'b0; i_fp = 32'h0; i_grp_ready = 1'b1;
        step(); step();
        i_reset_n = 1'b1;
        step();
        checks++;
        if ({o_fp_ready, o_grp_valid, o_busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/valid/busy=%b required 100", {o_fp_ready, o_grp_valid, o_busy});
        end
        checks++;
        if (o_grp_E !== 8'h00) begin
            errors++;
            $display("FAIL reset_E: got %h required 00", o_grp_E);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o_grp_M[i] !== 4'b0000) begin
                errors++;
                $display("FAIL reset_M[%0d]: got %b required 0000", i, o_grp_M[i]);
            end
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 16; i++) grp_vals[i] = 32'h3F800000;
        i_grp_ready = 1'b1;
        fill_group();
        checks++;
        if ({o_grp_valid, o_fp_ready, o_busy} !== 3'b001) begin
            errors++;
            $display("FAIL ones_align_flags: valid/ready/busy=%b required 001", {o_grp_valid, o_fp_ready, o_busy});
        end
        step();
        checks++;
        if ({o_grp_valid, o_fp_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ones_out_flags: valid/ready=%b required 10", {o_grp_valid, o_fp_ready});
        end
        checks++;
        if (o_grp_E !== 8'h7F) begin
            errors++;
            $display("FAIL ones_E: got %h required 7f", o_grp_E);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o_grp_M[i] !== 4'b0100) begin
                errors++;
                $display("FAIL ones_M[%0d]: got %b required 0100", i, o_grp_M[i]);
            end
        end
        step();
        checks++;
        if ({o_grp_valid, o_fp_ready, o_busy} !== 3'b010) begin
            errors++;
            $display("FAIL ones_after_hs: valid/ready/busy=%b required 010", {o_grp_valid, o_fp_ready, o_busy});
        end
        checks++;
        if (o_grp_E !== 8'h7F) begin
            errors++;
            $display("FAIL ones_E_held: got %h required 7f", o_grp_E);
        end
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 16; i++) begin
            grp_vals[i] = 32'h0;
            exp_m[i]    = 4'b0000;
        end
        grp_vals[0] = 32'h40800000; exp_m[0] = 4'b0100;
        grp_vals[1] = 32'h3F800000; exp_m[1] = 4'b0001;
        grp_vals[2] = 32'hC0000000; exp_m[2] = 4'b1010;
        grp_vals[3] = 32'h3FE00000;
`ifdef FP2BFP_ROUND_EN
        exp_m[3] = 4'b0010;
`else
        exp_m[3] = 4'b0001;
`endif
        fill_group();
        step();
        checks++;
        if (o_grp_valid !== 1'b1 || o_grp_E !== 8'h81) begin
            errors++;
            $display("FAIL mixed_E: valid=%b E=%h required 1/81", o_grp_valid, o_grp_E);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o_grp_M[i] !== exp_m[i]) begin
                errors++;
                $display("FAIL mixed_M[%0d]: got %b required %b", i, o_grp_M[i], exp_m[i]);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) grp_vals[i] = 32'h40400000;
        i_grp_ready = 1'b0;
        fill_group();
        step();
        i_fp_valid = 1'b1;
        i_fp       = 32'h7F800000;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({o_grp_valid, o_fp_ready} !== 2'b10 || o_grp_E !== 8'h80) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid/ready=%b E=%h required 10/80", c, {o_grp_valid, o_fp_ready}, o_grp_E);
            end
            checks++;
            if (o_grp_M[0] !== 4'b0110 || o_grp_M[15] !== 4'b0110) begin
                errors++;
                $display("FAIL bp_hold_M[%0d]: M0=%b M15=%b required 0110", c, o_grp_M[0], o_grp_M[15]);
            end
            step();
        end
        i_fp_valid  = 1'b0;
        i_grp_ready = 1'b1;
        step();
        checks++;
        if ({o_grp_valid, o_fp_ready, o_busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: valid/ready/busy=%b required 010", {o_grp_valid, o_fp_ready, o_busy});
        end
        for (int i = 0; i < 16; i++) grp_vals[i] = 32'h3F800000;
        fill_group();
        step();
        checks++;
        if (o_grp_E !== 8'h7F || o_grp_M[0] !== 4'b0100 || o_grp_M[15] !== 4'b0100) begin
            errors++;
            $display("FAIL bp_next_group: E=%h M0=%b M15=%b required 7f/0100/0100", o_grp_E, o_grp_M[0], o_grp_M[15]);
        end
        step();
    endtask

    task automatic test_reset_midfill();
        i_fp_valid = 1'b1;
        i_fp       = 32'h41000000;
        for (int c = 0; c < 7; c++) step();
        i_fp_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midfill_busy: got %b required 1", o_busy);
        end
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        checks++;
        if ({o_fp_ready, o_grp_valid, o_busy} !== 3'b100) begin
            errors++;
            $display("FAIL midfill_reset: ready/valid/busy=%b required 100", {o_fp_ready, o_grp_valid, o_busy});
        end
        for (int i = 0; i < 16; i++) grp_vals[i] = 32'h40000000;
        fill_group();
        step();
        checks++;
        if (o_grp_valid !== 1'b1 || o_grp_E !== 8'h80) begin
            errors++;
            $display("FAIL midfill_E: valid=%b E=%h required 1/80", o_grp_valid, o_grp_E);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o_grp_M[i] !== 4'b0100) begin
                errors++;
                $display("FAIL midfill_M[%0d]: got %b required 0100", i, o_grp_M[i]);
            end
        end
        step();
    endtask

    task automatic test_zero();
        for (int i = 0; i < 16; i++) grp_vals[i] = (i % 2 == 0) ? 32'h80000000 : 32'h00000001;
        fill_group();
        step();
        checks++;
        if (o_grp_valid !== 1'b1 || o_grp_E !== 8'h00) begin
            errors++;
            $display("FAIL zero_E: valid=%b E=%h required 1/00", o_grp_valid, o_grp_E);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o_grp_M[i] !== 4'b0000) begin
                errors++;
                $display("FAIL zero_M[%0d]: got %b required 0000", i, o_grp_M[i]);
            end
        end
        step();
    endtask

    task automatic test_streaming();
        int pulses = 0;
        i_grp_ready = 1'b1;
        i_fp_valid  = 1'b1;
        i_fp        = 32'h3F800000;
        for (int k = 0; k < 54; k++) begin
            checks++;
            if (o_fp_ready !== ((k % 18) < 16) || o_grp_valid !== ((k % 18) == 17)) begin
                errors++;
                $display("FAIL stream_cycle[%0d]: ready/valid=%b%b required %b%b", k, o_fp_ready, o_grp_valid,
                         ((k % 18) < 16), ((k % 18) == 17));
            end
            if (o_grp_valid === 1'b1) begin
                pulses++;
                checks++;
                if (o_grp_E !== 8'h7F) begin
                    errors++;
                    $display("FAIL stream_E[%0d]: got %h required 7f", k, o_grp_E);
                end
            end
            step();
        end
        i_fp_valid = 1'b0;
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL stream_pulses: got %0d required 3", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_mixed();
        test_backpressure();
        test_reset_midfill();
        test_zero();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
